seven_segment_scan: RTL and testbench
=====================================

# seven_segment_scan

Parametrised multiplexed seven-segment driver, successor to the two-digit alternating driver in the frequency counter. Holds a DIGITS-wide BCD/hex value captured on `load`, scans one digit per DWELL clock cycles onto a shared segment bus with a one-hot digit enable, and supports hex glyphs, per-digit decimal points and leading-zero blanking. Sits between the counter/measurement core and the board display pins.

## Interface
- DIGITS, 4, number of display digits; legal range 2..8.
- DWELL, 1, clock cycles each digit stays enabled before the scan advances; legal range 1..2^16.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture `value`, `dp_in`, `hex_mode`, `lz_blank` this cycle.
- value  input  4*DIGITS  digit nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 least significant.
- dp_in  input  DIGITS  decimal point per digit, bit i for digit i.
- hex_mode  input  1  1: nibbles 10..15 show A b C d E F; 0: nibbles 10..15 blank.
- lz_blank  input  1  1: blank leading zeros.
- segments  output  7  active-high, bit 0 = seg a … bit 6 = seg g; registered.
- dp  output  1  active-high decimal point for the enabled digit; registered.
- digit_en  output  DIGITS  one-hot active-high digit enable; registered.

## Operation
- Shadow registers: value_q, dp_q, hex_q, lz_q, valid_q. On `load`, all update atomically and valid_q <= 1. Without `load`, they hold.
- Scan: dwell counter 0..DWELL-1; at terminal count, counter -> 0 and index advances i -> i+1, DIGITS-1 wraps to 0. DWELL=1: index advances every cycle. `load` never disturbs the counter or index.
- Glyphs (gfedcba): 0 0111111, 1 0000110, 2 1011011, 3 1001111, 4 1100110, 5 1101101, 6 1111101, 7 0000111, 8 1111111, 9 1101111; hex: A 1110111, b 1111100, C 0111001, d 1011110, E 1111001, F 1110001. 6 and 9 use tailed forms so that 6 and b differ.
- Blanking (segments = 0) when any of: valid_q = 0; nibble ≥ 10 and hex_q = 0; lz_q = 1 and the digit is a leading zero.
- Leading zero: digit i (i ≥ 1) whose nibble is 0 and all higher nibbles are 0. Digit 0 is never blanked as a leading zero, so value 0 shows "0". A nibble ≥ 10 counts as non-zero.
- `dp` = dp_q[index] & valid_q. A decimal point is shown even on a blanked digit.
- digit_en = one-hot of index.

## Timing
- Reset values: index 0, dwell counter 0, valid_q 0, value_q 0, dp_q 0, hex_q 0, lz_q 0. Outputs: segments 0, dp 0, digit_en 0.
- Output registers update every cycle from the current index and shadow registers. The first cycle after reset deasserts shows digit_en = 1 (digit 0), with segments 0.
- Latency: `load` at edge N -> new glyph visible at edge N+1 for whichever digit is enabled then. Index change -> digit_en, segments and dp change together on the same edge; no cycle has mismatched enable and segment data.
- Reset mid-scan or while `load` is high: reset wins, and all state returns to its reset values.
- Dwell counter width is $clog2(DWELL) (minimum 1); index width is $clog2(DIGITS).

## Structure
- Shared package seven_segment_pkg: glyph constants (SEG_0..SEG_F, SEG_BLANK), segment bit-order constants, and a function `nibble_to_seg(nibble, hex)` returning 7 bits.
- One sub-module: seven_segment_decode, a combinational nibble+hex -> segments block wrapping the package function. It is reusable by the legacy driver.
- Leading-zero mask: combinational prefix-OR from the MSB digit down. It is computed once per load from the shadow registers, not per scan step.

## Test plan
- Reset then no load, DIGITS=4, DWELL=1 -> digit_en cycles 0001,0010,0100,1000,0001; segments and dp are 0 throughout.
- load value=16'h1234, hex_mode=0 -> digit 0 0011... i.e. digit 0 shows 1100110 (4), digit 1 shows 1001111 (3), digit 2 shows 1011011 (2), digit 3 shows 0000110 (1).
- load 16'h00A5, hex_mode=0, then hex_mode=1 -> first: digit 1 blank, digit 0 1101101; second: digit 1 1110111 (A).
- load 16'h0007, lz_blank=1 -> digits 3..1 blank, digit 0 0000111. Then load 16'h0000 -> only digit 0 shows 0111111.
- DWELL=3, dp_in=4'b0100 -> each digit_en value is held exactly 3 cycles; dp = 1 only while digit_en = 0100.
- Reset asserted while digit 2 is enabled, mid-dwell -> next edge: all outputs 0, index 0, valid_q 0. A load in the same cycle is ignored.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: segment bit order, glyph constants and
// the nibble-to-glyph function used by the decoder and the scan driver.
package seven_segment_pkg;

  localparam int unsigned SEG_W = 7;

  // Segment bit positions inside a glyph (gfedcba).
  localparam int unsigned SEG_BIT_A = 0;
  localparam int unsigned SEG_BIT_B = 1;
  localparam int unsigned SEG_BIT_C = 2;
  localparam int unsigned SEG_BIT_D = 3;
  localparam int unsigned SEG_BIT_E = 4;
  localparam int unsigned SEG_BIT_F = 5;
  localparam int unsigned SEG_BIT_G = 6;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  // 6 and 9 carry tails so that 6 cannot be confused with b.
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b0111001;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b1011110;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b1110001;

  // Glyph for one nibble; 10..15 are blank unless hex is set.
  function automatic logic [SEG_W-1:0] nibble_to_seg(input logic [3:0] nibble,
                                                     input logic       hex);
    logic [SEG_W-1:0] seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex ? SEG_A : SEG_BLANK;
      4'hB: seg = hex ? SEG_B : SEG_BLANK;
      4'hC: seg = hex ? SEG_C : SEG_BLANK;
      4'hD: seg = hex ? SEG_D : SEG_BLANK;
      4'hE: seg = hex ? SEG_E : SEG_BLANK;
      4'hF: seg = hex ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational nibble -> seven-segment glyph decoder.
// Ports: nibble (4-bit digit), hex (show A..F for 10..15),
//        segments_c (active-high gfedcba, combinational).
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             hex,
  output logic [SEG_W-1:0] segments_c
);

  assign segments_c = nibble_to_seg(nibble, hex);

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scan driver: captures a DIGITS-wide nibble value
// on load and scans one digit per DWELL cycles onto a shared segment bus.
// Ports: clk, reset (sync, active-high), load, value, dp_in, hex_mode,
//        lz_blank in; segments, dp, digit_en out (all registered).
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DWELL  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  hex_mode,
  input  logic                  lz_blank,
  output logic [SEG_W-1:0]      segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [VAL_W-1:0]  value_q;
  logic [DIGITS-1:0] dp_q;
  logic              hex_q;
  logic              lz_q;
  logic              valid_q;

  logic [CNT_W-1:0]  dwell_cnt;
  logic [IDX_W-1:0]  idx;

  logic [DIGITS-1:0] nz_above;
  logic [DIGITS-1:0] lz_mask;
  logic [3:0]        cur_nibble;
  logic [SEG_W-1:0]  dec_seg_c;
  logic [SEG_W-1:0]  seg_d;
  logic              dp_d;
  logic [DIGITS-1:0] en_d;

  // Shadow registers, updated atomically on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      dp_q    <= '0;
      hex_q   <= 1'b0;
      lz_q    <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      value_q <= value;
      dp_q    <= dp_in;
      hex_q   <= hex_mode;
      lz_q    <= lz_blank;
      valid_q <= 1'b1;
    end
  end

  // Dwell counter and digit index; independent of load.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_cnt <= '0;
      idx       <= '0;
    end else if (dwell_cnt == CNT_LAST) begin
      dwell_cnt <= '0;
      idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

  // Prefix-OR from the MSB digit: nz_above[i] set when digit i or any higher
  // digit is non-zero. Only changes when value_q does, i.e. once per load.
  always_comb begin
    nz_above = '0;
    nz_above[DIGITS-1] = |value_q[VAL_W-1 -: 4];
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      nz_above[i] = nz_above[i+1] | (|value_q[4*i +: 4]);
    end
    lz_mask    = ~nz_above;
    lz_mask[0] = 1'b0;
  end

  assign cur_nibble = value_q[{idx, 2'b00} +: 4];

  seven_segment_decode u_decode (
    .nibble     (cur_nibble),
    .hex        (hex_q),
    .segments_c (dec_seg_c)
  );

  // Next output values, all derived from the same index so they stay aligned.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = dp_q[idx] & valid_q;
    en_d  = DIGITS'(1) << idx;
    if (valid_q && !(lz_q && lz_mask[idx])) begin
      seg_d = dec_seg_c;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      segments <= SEG_BLANK;
      dp       <= 1'b0;
      digit_en <= '0;
    end else begin
      segments <= seg_d;
      dp       <= dp_d;
      digit_en <= en_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan: two instances (DWELL=1 and
// DWELL=3) share the inputs and are compared against a cycle-count model.
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        hex_mode;
  logic        lz_blank;

  logic [6:0]  seg1, seg3;
  logic        dp1, dp3;
  logic [3:0]  en1, en3;

  int checks = 0;
  int errors = 0;

  seven_segment_scan #(.DIGITS(4), .DWELL(1)) u_dut1 (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .hex_mode(hex_mode), .lz_blank(lz_blank),
    .segments(seg1), .dp(dp1), .digit_en(en1)
  );

  seven_segment_scan #(.DIGITS(4), .DWELL(3)) u_dut3 (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .hex_mode(hex_mode), .lz_blank(lz_blank),
    .segments(seg3), .dp(dp3), .digit_en(en3)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          cyc;
  logic        m_valid, m_hex, m_lz;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic [6:0]  e_seg1, e_seg3;
  logic        e_dp1, e_dp3;
  logic [3:0]  e_en1, e_en3;

  function automatic logic [6:0] model_seg(int idx);
    logic [15:0] upper;
    int nib;
    upper = m_value >> (4 * idx);
    nib   = int'(upper & 16'hF);
    if (!m_valid) return 7'b0;
    if (nib >= 10 && !m_hex) return 7'b0;
    if (m_lz && idx >= 1 && upper == 16'h0) return 7'b0;
    return glyph[nib];
  endfunction

  always @(posedge clk) begin
    int i1, i3;
    if (reset) begin
      cyc = 0; m_valid = 0; m_hex = 0; m_lz = 0; m_value = '0; m_dp = '0;
      e_seg1 = '0; e_dp1 = 0; e_en1 = '0;
      e_seg3 = '0; e_dp3 = 0; e_en3 = '0;
    end else begin
      i1 = cyc % 4;
      i3 = (cyc / 3) % 4;
      e_seg1 = model_seg(i1); e_dp1 = m_dp[i1] & m_valid; e_en1 = 4'(1 << i1);
      e_seg3 = model_seg(i3); e_dp3 = m_dp[i3] & m_valid; e_en3 = 4'(1 << i3);
      cyc++;
      if (load) begin
        m_valid = 1; m_value = value; m_dp = dp_in; m_hex = hex_mode; m_lz = lz_blank;
      end
    end
  end

  // One clock: outputs are sampled on the falling edge after it.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; load = 1; value = 16'h9876; dp_in = 4'hF; hex_mode = 1; lz_blank = 0;
    repeat (3) cycle();
    checks++;
    if ({seg1, dp1, en1, seg3, dp3, en3} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got seg1=%b en1=%b seg3=%b en3=%b need all 0", seg1, en1, seg3, en3);
    end
    reset = 0; load = 0;
    cycle();
    checks++;
    if (en1 !== 4'b0001 || seg1 !== 7'b0 || dp1 !== 1'b0 || en3 !== 4'b0001 || seg3 !== 7'b0) begin
      errors++;
      $display("FAIL first_after_reset got en1=%b seg1=%b dp1=%b en3=%b seg3=%b need 0001/0/0/0001/0",
               en1, seg1, dp1, en3, seg3);
    end
  endtask

  task automatic test_scan_no_load();
    logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (en1 !== seq[k] || seg1 !== 7'b0 || dp1 !== 1'b0) begin
        errors++;
        $display("FAIL scan_no_load step %0d got en=%b seg=%b dp=%b need en=%b seg=0 dp=0",
                 k, en1, seg1, dp1, seq[k]);
      end
      checks++;
      if ({seg1, dp1, en1, seg3, dp3, en3} !== {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3}) begin
        errors++;
        $display("FAIL scan_no_load_model got %h need %h", {seg1, dp1, en1, seg3, dp3, en3},
                 {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3});
      end
    end
  endtask

  task automatic test_decimal();
    logic [6:0] want [4] = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
    load = 1; value = 16'h1234; dp_in = 4'h0; hex_mode = 0; lz_blank = 0;
    cycle();
    load = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      for (int d = 0; d < 4; d++) begin
        if (en1[d]) begin
          checks++;
          if (seg1 !== want[d]) begin
            errors++;
            $display("FAIL decimal_1234 digit %0d got %b need %b", d, seg1, want[d]);
          end
        end
      end
      checks++;
      if ({seg1, dp1, en1, seg3, dp3, en3} !== {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3}) begin
        errors++;
        $display("FAIL decimal_model got %h need %h", {seg1, dp1, en1, seg3, dp3, en3},
                 {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3});
      end
    end
  endtask

  task automatic test_hex();
    for (int pass = 0; pass < 2; pass++) begin
      load = 1; value = 16'h00A5; hex_mode = (pass == 1); lz_blank = 0; dp_in = 4'h0;
      cycle();
      load = 0;
      for (int k = 0; k < 4; k++) begin
        cycle();
        if (en1 == 4'b0010) begin
          checks++;
          if (seg1 !== ((pass == 1) ? 7'b1110111 : 7'b0000000)) begin
            errors++;
            $display("FAIL hex_digit1 pass %0d got %b need %b", pass, seg1,
                     (pass == 1) ? 7'b1110111 : 7'b0000000);
          end
        end
        if (en1 == 4'b0001) begin
          checks++;
          if (seg1 !== 7'b1101101) begin
            errors++;
            $display("FAIL hex_digit0 pass %0d got %b need 1101101", pass, seg1);
          end
        end
        checks++;
        if ({seg1, dp1, en1, seg3, dp3, en3} !== {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3}) begin
          errors++;
          $display("FAIL hex_model got %h need %h", {seg1, dp1, en1, seg3, dp3, en3},
                   {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3});
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] vals [2] = '{16'h0007, 16'h0000};
    logic [6:0]  d0   [2] = '{7'b0000111, 7'b0111111};
    for (int pass = 0; pass < 2; pass++) begin
      load = 1; value = vals[pass]; lz_blank = 1; hex_mode = 0; dp_in = 4'h0;
      cycle();
      load = 0;
      for (int k = 0; k < 4; k++) begin
        cycle();
        checks++;
        if (seg1 !== ((en1 == 4'b0001) ? d0[pass] : 7'b0)) begin
          errors++;
          $display("FAIL lz_blank value %h en %b got %b need %b", vals[pass], en1, seg1,
                   (en1 == 4'b0001) ? d0[pass] : 7'b0);
        end
      end
    end
  endtask

  task automatic test_dwell3_dp();
    logic [3:0] prev;
    int run;
    bit first;
    load = 1; value = 16'($urandom); dp_in = 4'b0100; hex_mode = 1; lz_blank = 0;
    cycle();
    load = 0;
    prev = en3; run = 1; first = 1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      checks++;
      if (dp3 !== (en3 == 4'b0100)) begin
        errors++;
        $display("FAIL dwell3_dp en %b got dp %b need %b", en3, dp3, en3 == 4'b0100);
      end
      if (en3 == prev) begin
        run++;
      end else begin
        if (!first) begin
          checks++;
          if (run != 3) begin
            errors++;
            $display("FAIL dwell3_hold en %b held %0d cycles need 3", prev, run);
          end
        end
        first = 0; prev = en3; run = 1;
      end
      checks++;
      if ({seg1, dp1, en1, seg3, dp3, en3} !== {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3}) begin
        errors++;
        $display("FAIL dwell3_model got %h need %h", {seg1, dp1, en1, seg3, dp3, en3},
                 {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3});
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (en3 == 4'b0100) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_wait digit 2 never enabled got en3=%b need 0100", en3);
    end
    cycle();
    reset = 1; load = 1; value = 16'h4321; dp_in = 4'hF; hex_mode = 1;
    cycle();
    checks++;
    if ({seg1, dp1, en1, seg3, dp3, en3} !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %h need 0", {seg1, dp1, en1, seg3, dp3, en3});
    end
    reset = 0; load = 0;
    cycle();
    checks++;
    if (en1 !== 4'b0001 || en3 !== 4'b0001 || seg1 !== 7'b0 || seg3 !== 7'b0 || dp1 !== 1'b0 || dp3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_restart got en1=%b en3=%b seg1=%b seg3=%b dp=%b%b need 0001 0001 0 0 00",
               en1, en3, seg1, seg3, dp1, dp3);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      reset    = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 2) == 0);
      value    = 16'($urandom);
      if ($urandom_range(0, 1) == 1) value = value & 16'h00FF;
      dp_in    = 4'($urandom);
      hex_mode = 1'($urandom);
      lz_blank = 1'($urandom);
      cycle();
      checks++;
      if ({seg1, dp1, en1, seg3, dp3, en3} !== {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3}) begin
        errors++;
        $display("FAIL random_model cycle %0d got %h need %h", k, {seg1, dp1, en1, seg3, dp3, en3},
                 {e_seg1, e_dp1, e_en1, e_seg3, e_dp3, e_en3});
      end
    end
    reset = 0; load = 0;
  endtask

  initial begin
    reset = 1; load = 0; value = '0; dp_in = '0; hex_mode = 0; lz_blank = 0;
    @(negedge clk);
    test_reset();
    test_scan_no_load();
    test_decimal();
    test_hex();
    test_lz_blank();
    test_dwell3_dp();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
